anti_theft_fsm: RTL and testbench
=================================

Name: anti_theft_fsm

Overview:
Top-level sequencing controller for the car alarm. It watches ignition and door inputs, selects the countdown interval, loads it into the shared one-second countdown timer with a start pulse, and reacts to the timer's expired flag. It drives the siren and the status LED. It sits between the debounced sensor inputs and the timer instance, and is the only agent that drives the timer's start_timer and value inputs.

Parameters:
T_ARM_DELAY, 6, seconds from the last door close until the system re-arms.
T_DRIVER_DELAY, 8, grace seconds after the driver door opens while armed.
T_PASSENGER_DELAY, 15, grace seconds after the passenger door opens while armed.
T_ALARM_ON, 10, seconds the siren stays on after all doors close during an alarm.
All four are 4 bits wide. Legal range is 1..15; 0 is illegal.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
ignition  in  1  ignition switch; synchronous, debounced
door_driver  in  1  1 = driver door open
door_pass  in  1  1 = passenger door open
expired  in  1  from timer; 1 when count is 0
half_hz_enable  in  1  from timer; square wave used for the armed-state blink
start_timer  out  1  one-cycle load pulse to the timer
timer_value  out  4  interval to load; valid while start_timer = 1
siren  out  1  siren drive
status_led  out  1  status LED drive
state_dbg  out  3  current state encoding, for display and debug
fuel_pump_power  out  1  fuel pump enable (see Optional Feature)

Behaviour:
- States and encoding: ARMED=0, TRIGGERED=1, SOUND=2, HOLD=3, DISARMED=4, WAIT_OPEN=5, WAIT_CLOSE=6, ARM_DELAY=7.
- Reset: state=ARMED; start_timer=0; timer_value=0; siren=0; fuel_pump_power=0; state_dbg=0.
- start_timer and timer_value are registered.
  - The pulse is asserted in the first cycle of the state being entered, for exactly 1 cycle.
  - expired is ignored in that cycle. A guard flag is set by the pulse and cleared one cycle later.
- Priority: ignition=1 in ARMED, TRIGGERED, SOUND or HOLD forces DISARMED on the next edge, overriding every other condition.
- ARMED:
  - door_driver=1 -> TRIGGERED, load T_DRIVER_DELAY.
  - else door_pass=1 -> TRIGGERED, load T_PASSENGER_DELAY.
  - Both doors open in the same cycle -> driver delay wins.
- TRIGGERED: expired (guard clear) -> SOUND. No reload. Door state is ignored.
- SOUND: both doors closed -> HOLD, load T_ALARM_ON.
- HOLD:
  - Any door opens -> SOUND.
  - else expired (guard clear) -> ARMED.
  - Door open and expired in the same cycle -> SOUND.
- DISARMED: ignition=0 -> WAIT_OPEN.
- WAIT_OPEN:
  - ignition=1 -> DISARMED.
  - door_driver=1 -> WAIT_CLOSE.
- WAIT_CLOSE:
  - ignition=1 -> DISARMED.
  - both doors closed -> ARM_DELAY, load T_ARM_DELAY.
- ARM_DELAY:
  - ignition=1 -> DISARMED.
  - any door opens -> WAIT_CLOSE (the delay restarts on the next close).
  - else expired (guard clear) -> ARMED.
- Outputs per state:
  - siren = 1 only in SOUND and HOLD.
  - status_led = half_hz_enable in ARMED; 1 in TRIGGERED, SOUND and HOLD; 0 otherwise.
  - siren and status_led are combinational from state.
- Reset mid-operation returns to ARMED and cancels any pending pulse. The timer is reset by the same signal.

Optional Feature:
Macro ANTI_THEFT_FUEL_PUMP_EN.
- Defined: fuel_pump_power is set when ignition=1 and hidden_switch=1 and brake_pedal=1 in the same cycle. It is cleared on the cycle after ignition=0.
  - Two extra 1-bit inputs are added: hidden_switch and brake_pedal.
  - The pump flag is independent of the state machine.
- Undefined: those two inputs are absent and fuel_pump_power is tied to 0.

Decomposition:
- Package anti_theft_pkg holds:
  - the 3-bit state enum typedef;
  - the 2-bit interval-select typedef (ARM, DRIVER, PASSENGER, ALARM);
  - default interval constants.
- Sub-module anti_theft_interval_sel: combinational mux from interval select to the 4-bit value using the parameters. It is the single natural split.
- The FSM, pulse generator and guard flag stay in the top module.

Test Plan:
1. Reset, then door_driver=1 for 1 cycle -> next cycle state=TRIGGERED, start_timer=1, timer_value=8, status_led=1.
2. In TRIGGERED, hold expired=1 through the guard cycle -> no transition in the guard cycle; SOUND one cycle later; siren=1.
3. In SOUND, close both doors -> HOLD, timer_value=10. Reopen door_pass -> SOUND. Close again, then expired -> ARMED, siren=0.
4. In ARMED, door_driver=1 and door_pass=1 in the same cycle -> timer_value=8 (not 15). In SOUND, ignition=1 -> DISARMED, siren=0, status_led=0.
5. Run DISARMED, ignition off, driver open/close -> ARM_DELAY with timer_value=6. Reopen the door mid-delay -> WAIT_CLOSE. Close -> a new pulse with timer_value=6. Then expired -> ARMED and the LED follows half_hz_enable.
6. Assert reset during HOLD -> state_dbg=0, siren=0, start_timer=0 immediately (async). With ANTI_THEFT_FUEL_PUMP_EN defined: ignition, hidden_switch and brake_pedal all 1 -> fuel_pump_power=1; ignition=0 -> fuel_pump_power=0.

Source files
------------

// File: rtl/anti_theft_pkg.sv
// Shared types and default intervals for the car-alarm sequencing controller.
// Optional fuel-pump interlock in the top module is enabled by ANTI_THEFT_FUEL_PUMP_EN.
package anti_theft_pkg;

    // Controller states; encodings are visible on state_dbg.
    typedef enum logic [2:0] {
        ARMED      = 3'd0,
        TRIGGERED  = 3'd1,
        SOUND      = 3'd2,
        HOLD       = 3'd3,
        DISARMED   = 3'd4,
        WAIT_OPEN  = 3'd5,
        WAIT_CLOSE = 3'd6,
        ARM_DELAY  = 3'd7
    } state_t;

    // Which countdown interval to load into the shared timer.
    typedef enum logic [1:0] {
        ARM       = 2'd0,
        DRIVER    = 2'd1,
        PASSENGER = 2'd2,
        ALARM     = 2'd3
    } interval_sel_t;

    // Default intervals in seconds (legal range 1..15).
    localparam logic [3:0] DEFAULT_ARM_DELAY       = 4'd6;
    localparam logic [3:0] DEFAULT_DRIVER_DELAY    = 4'd8;
    localparam logic [3:0] DEFAULT_PASSENGER_DELAY = 4'd15;
    localparam logic [3:0] DEFAULT_ALARM_ON        = 4'd10;

endpackage

// File: rtl/anti_theft_interval_sel.sv
// Maps an interval select code onto the configured 4-bit countdown value.
module anti_theft_interval_sel
    import anti_theft_pkg::*;
#(
    parameter logic [3:0] T_ARM_DELAY       = DEFAULT_ARM_DELAY,
    parameter logic [3:0] T_DRIVER_DELAY    = DEFAULT_DRIVER_DELAY,
    parameter logic [3:0] T_PASSENGER_DELAY = DEFAULT_PASSENGER_DELAY,
    parameter logic [3:0] T_ALARM_ON        = DEFAULT_ALARM_ON
) (
    input  logic [1:0] sel,
    output logic [3:0] value
);

    // Select the interval that matches the requested phase.
    always_comb begin
        value = T_ARM_DELAY;
        case (sel)
            ARM:       value = T_ARM_DELAY;
            DRIVER:    value = T_DRIVER_DELAY;
            PASSENGER: value = T_PASSENGER_DELAY;
            ALARM:     value = T_ALARM_ON;
            default:   value = T_ARM_DELAY;
        endcase
    end

endmodule

// File: rtl/anti_theft_fsm.sv
// Car-alarm sequencing controller: watches ignition and doors, loads the shared
// countdown timer, reacts to expiry, and drives siren and status LED.
// Define ANTI_THEFT_FUEL_PUMP_EN to add the hidden-switch fuel-pump interlock.
module anti_theft_fsm
    import anti_theft_pkg::*;
#(
    parameter logic [3:0] T_ARM_DELAY       = DEFAULT_ARM_DELAY,
    parameter logic [3:0] T_DRIVER_DELAY    = DEFAULT_DRIVER_DELAY,
    parameter logic [3:0] T_PASSENGER_DELAY = DEFAULT_PASSENGER_DELAY,
    parameter logic [3:0] T_ALARM_ON        = DEFAULT_ALARM_ON
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       expired,
    input  logic       half_hz_enable,
`ifdef ANTI_THEFT_FUEL_PUMP_EN
    input  logic       hidden_switch,
    input  logic       brake_pedal,
`endif
    output logic       start_timer,
    output logic [3:0] timer_value,
    output logic       siren,
    output logic       status_led,
    output logic [2:0] state_dbg,
    output logic       fuel_pump_power
);

    state_t        state;
    state_t        next_state;
    logic          load;
    interval_sel_t sel;
    logic [3:0]    sel_value;
    logic          guard;
    logic          expired_seen;
    logic          any_door;

    anti_theft_interval_sel #(
        .T_ARM_DELAY      (T_ARM_DELAY),
        .T_DRIVER_DELAY   (T_DRIVER_DELAY),
        .T_PASSENGER_DELAY(T_PASSENGER_DELAY),
        .T_ALARM_ON       (T_ALARM_ON)
    ) u_interval_sel (
        .sel  (sel),
        .value(sel_value)
    );

    // The timer still shows the old count while it is being loaded, so expired
    // is masked during the load-pulse cycle.
    assign expired_seen = expired && !guard;
    assign any_door     = door_driver || door_pass;
    assign state_dbg    = state;

    // State register plus the registered timer load pulse, value and guard.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ARMED;
            start_timer <= 1'b0;
            timer_value <= '0;
            guard       <= 1'b0;
        end else begin
            state       <= next_state;
            start_timer <= load;
            guard       <= load;
            if (load) begin
                timer_value <= sel_value;
            end
        end
    end

    // Next-state and timer-load decision; ignition overrides the alarm side.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        sel        = ARM;
        case (state)
            ARMED: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (door_driver) begin
                    next_state = TRIGGERED;
                    load       = 1'b1;
                    sel        = DRIVER;
                end else if (door_pass) begin
                    next_state = TRIGGERED;
                    load       = 1'b1;
                    sel        = PASSENGER;
                end
            end
            TRIGGERED: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (expired_seen) begin
                    next_state = SOUND;
                end
            end
            SOUND: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (!any_door) begin
                    next_state = HOLD;
                    load       = 1'b1;
                    sel        = ALARM;
                end
            end
            HOLD: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (any_door) begin
                    next_state = SOUND;
                end else if (expired_seen) begin
                    next_state = ARMED;
                end
            end
            DISARMED: begin
                if (!ignition) begin
                    next_state = WAIT_OPEN;
                end
            end
            WAIT_OPEN: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (door_driver) begin
                    next_state = WAIT_CLOSE;
                end
            end
            WAIT_CLOSE: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (!any_door) begin
                    next_state = ARM_DELAY;
                    load       = 1'b1;
                    sel        = ARM;
                end
            end
            ARM_DELAY: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (any_door) begin
                    next_state = WAIT_CLOSE;
                end else if (expired_seen) begin
                    next_state = ARMED;
                end
            end
            default: next_state = ARMED;
        endcase
    end

    // Siren and LED decoded directly from the current state.
    always_comb begin
        siren      = 1'b0;
        status_led = 1'b0;
        case (state)
            ARMED:     status_led = half_hz_enable;
            TRIGGERED: status_led = 1'b1;
            SOUND: begin
                siren      = 1'b1;
                status_led = 1'b1;
            end
            HOLD: begin
                siren      = 1'b1;
                status_led = 1'b1;
            end
            default: begin
                siren      = 1'b0;
                status_led = 1'b0;
            end
        endcase
    end

`ifdef ANTI_THEFT_FUEL_PUMP_EN
    // Fuel pump latches on with the secret combination, drops with ignition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fuel_pump_power <= 1'b0;
        end else if (!ignition) begin
            fuel_pump_power <= 1'b0;
        end else if (hidden_switch && brake_pedal) begin
            fuel_pump_power <= 1'b1;
        end
    end
`else
    assign fuel_pump_power = 1'b0;
`endif

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Scoreboard bench for anti_theft_fsm: directed walk through the alarm
// scenarios, a randomized phase, and an asynchronous reset during HOLD.
// Also covers the fuel-pump interlock when ANTI_THEFT_FUEL_PUMP_EN is defined.
module tb_anti_theft_fsm;

    localparam int S_ARMED  = 0;
    localparam int S_TRIG   = 1;
    localparam int S_SOUND  = 2;
    localparam int S_HOLD   = 3;
    localparam int S_DIS    = 4;
    localparam int S_WOPEN  = 5;
    localparam int S_WCLOSE = 6;
    localparam int S_ADELAY = 7;

    localparam int T_ARM   = 6;
    localparam int T_DRV   = 8;
    localparam int T_PASS  = 15;
    localparam int T_ALARM = 10;

    logic       clock          = 1'b0;
    logic       reset          = 1'b1;
    logic       ignition       = 1'b0;
    logic       door_driver    = 1'b0;
    logic       door_pass      = 1'b0;
    logic       expired        = 1'b0;
    logic       half_hz_enable = 1'b0;
`ifdef ANTI_THEFT_FUEL_PUMP_EN
    logic       hidden_switch  = 1'b0;
    logic       brake_pedal    = 1'b0;
`endif
    logic       start_timer;
    logic [3:0] timer_value;
    logic       siren;
    logic       status_led;
    logic [2:0] state_dbg;
    logic       fuel_pump_power;

    anti_theft_fsm dut (
        .clock          (clock),
        .reset          (reset),
        .ignition       (ignition),
        .door_driver    (door_driver),
        .door_pass      (door_pass),
        .expired        (expired),
        .half_hz_enable (half_hz_enable),
`ifdef ANTI_THEFT_FUEL_PUMP_EN
        .hidden_switch  (hidden_switch),
        .brake_pedal    (brake_pedal),
`endif
        .start_timer    (start_timer),
        .timer_value    (timer_value),
        .siren          (siren),
        .status_led     (status_led),
        .state_dbg      (state_dbg),
        .fuel_pump_power(fuel_pump_power)
    );

    always #5 clock = ~clock;

    typedef struct {
        int state;
        bit siren;
        bit led;
        bit pulse;
        bit fuel;
    } exp_t;

    exp_t exp_q[$];
    int   pulse_q[$];

    int m_state = S_ARMED;
    bit m_fresh = 1'b0;
    bit m_fuel  = 1'b0;

    int checks   = 0;
    int failures = 0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Reference behaviour: apply the alarm rules to one cycle of inputs.
    function automatic void model_step(bit ign, bit dd, bit dp, bit ex);
        bit any_open   = dd || dp;
        bit exp_seen   = ex && !m_fresh;
        bit alarm_side = (m_state <= S_HOLD);
        int load       = 0;
        int nxt        = m_state;
        if (ign && alarm_side) begin
            nxt = S_DIS;
        end else begin
            case (m_state)
                S_ARMED: begin
                    if (dd) begin
                        nxt = S_TRIG; load = T_DRV;
                    end else if (dp) begin
                        nxt = S_TRIG; load = T_PASS;
                    end
                end
                S_TRIG:  if (exp_seen) nxt = S_SOUND;
                S_SOUND: if (!any_open) begin nxt = S_HOLD; load = T_ALARM; end
                S_HOLD: begin
                    if (any_open) nxt = S_SOUND;
                    else if (exp_seen) nxt = S_ARMED;
                end
                S_DIS:   if (!ign) nxt = S_WOPEN;
                S_WOPEN: begin
                    if (ign) nxt = S_DIS;
                    else if (dd) nxt = S_WCLOSE;
                end
                S_WCLOSE: begin
                    if (ign) nxt = S_DIS;
                    else if (!any_open) begin nxt = S_ADELAY; load = T_ARM; end
                end
                default: begin
                    if (ign) nxt = S_DIS;
                    else if (any_open) nxt = S_WCLOSE;
                    else if (exp_seen) nxt = S_ARMED;
                end
            endcase
        end
        if (load != 0) pulse_q.push_back(load);
        m_fresh = (load != 0);
        m_state = nxt;
    endfunction

    // Drive one cycle of inputs and queue the response expected after the edge.
    task automatic cycle(bit ign, bit dd, bit dp, bit ex, bit hz);
        exp_t e;
        @(negedge clock);
        ignition       = ign;
        door_driver    = dd;
        door_pass      = dp;
        expired        = ex;
        half_hz_enable = hz;
`ifdef ANTI_THEFT_FUEL_PUMP_EN
        m_fuel = ign ? (m_fuel | (hidden_switch & brake_pedal)) : 1'b0;
`endif
        model_step(ign, dd, dp, ex);
        e.state = m_state;
        e.siren = (m_state == S_SOUND) || (m_state == S_HOLD);
        e.led   = (m_state == S_ARMED) ? hz : (m_state >= S_TRIG && m_state <= S_HOLD);
        e.pulse = m_fresh;
        e.fuel  = m_fuel;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        ignition       = 1'b0;
        door_driver    = 1'b0;
        door_pass      = 1'b0;
        expired        = 1'b0;
        half_hz_enable = 1'b0;
`ifdef ANTI_THEFT_FUEL_PUMP_EN
        hidden_switch  = 1'b0;
        brake_pedal    = 1'b0;
`endif
        reset = 1'b1;
        #1;
        check("rst_state_dbg", state_dbg, S_ARMED);
        check("rst_start_timer", start_timer, 0);
        check("rst_timer_value", timer_value, 0);
        check("rst_siren", siren, 0);
        check("rst_status_led", status_led, 0);
        check("rst_fuel", fuel_pump_power, 0);
        exp_q.delete();
        pulse_q.delete();
        m_state = S_ARMED;
        m_fresh = 1'b0;
        m_fuel  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: compare each presented cycle against the scoreboard.
    initial begin
        forever begin
            exp_t e;
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state_dbg", state_dbg, e.state);
                check("siren", siren, e.siren);
                check("status_led", status_led, e.led);
                check("start_timer", start_timer, e.pulse);
                check("fuel_pump_power", fuel_pump_power, e.fuel);
                if (start_timer) begin
                    check("pulse_pending", (pulse_q.size() > 0), 1);
                    if (pulse_q.size() > 0) check("timer_value", timer_value, pulse_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit ign = 1'b0;
        bit dd  = 1'b0;
        bit dp  = 1'b0;
        bit hz  = 1'b0;

        do_reset();

        // Driver door while armed, guard cycle, then sound.
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        // Hold, reopen, hold again, expire back to armed.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        // Both doors at once: driver interval wins; ignition in SOUND disarms.
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 1, 0);
        cycle(0, 1, 1, 1, 0);
        cycle(1, 1, 1, 0, 0);
        // Disarmed walk-away with a restarted arm delay.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) ign = ~ign;
            if ($urandom_range(0, 5) == 0)  dd  = ~dd;
            if ($urandom_range(0, 7) == 0)  dp  = ~dp;
            if ($urandom_range(0, 3) == 0)  hz  = ~hz;
`ifdef ANTI_THEFT_FUEL_PUMP_EN
            hidden_switch = ($urandom_range(0, 3) == 0);
            brake_pedal   = ($urandom_range(0, 2) == 0);
`endif
            cycle(ign, dd, dp, ($urandom_range(0, 3) == 0), hz);
        end

        // Asynchronous reset in the first HOLD cycle cancels the pending pulse.
        @(posedge clock);
        #2;
        do_reset();
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        @(posedge clock);
        #2;
        check("hold_siren_before_reset", siren, 1);
        check("hold_pulse_before_reset", start_timer, 1);
        do_reset();

`ifdef ANTI_THEFT_FUEL_PUMP_EN
        hidden_switch = 1'b1;
        brake_pedal   = 1'b1;
        cycle(1, 0, 0, 0, 0);
        hidden_switch = 1'b0;
        brake_pedal   = 1'b0;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
`endif

        @(posedge clock);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        check("pulses_drained", pulse_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
